serial_status_tx: RTL and testbench
===================================

Name: serial_status_tx

Overview:
- FPGA-to-MBED transmitter for the bit-serial ready/bit/ack handshake; the reverse direction of the instruction receiver.
- Serialises a WIDTH-bit status word (servo state, task_finished, limit switches) MSB first.
- The FPGA is the initiator and the MBED is the acknowledger.
- Sits beside the instruction receiver in the top level; its send strobe comes from the servo state machine.

Parameters:
WIDTH, 10, bits per status word (>=2)
SETUP_CYCLES, 24, clk cycles tx_bit is held stable before tx_ready rises (1 us at 24 MHz)
ACK_TIMEOUT, 240000, clk cycles allowed in each ack-wait state before abort (10 ms at 24 MHz)

Ports:
clk  in  1  system clock, 24 MHz
reset  in  1  synchronous, active-high
send  in  1  one-cycle request; word is captured when send=1 and busy=0
word  in  WIDTH  status word to transmit
tx_ack  in  1  acknowledge from MBED, asynchronous to clk
tx_ready  out  1  FPGA has a valid bit on tx_bit
tx_bit  out  1  serial data line
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the last bit's handshake completes
timeout_err  out  1  one-cycle pulse when a transfer is aborted by timeout
state_dbg  out  2  current state encoding, for LEDs

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; shift register, bit counter and timer cleared.
- Reset wins over every other event, including send and an active transfer. A reset mid-transfer drops tx_ready and busy at the next edge; no done or timeout_err pulse is produced.
- tx_ack passes through a 2-flop synchroniser to give ack_s. All decisions use ack_s only, so there are 2 cycles of latency from a tx_ack edge.
- States (state_dbg): IDLE=0, SETUP=1, WAIT_HI=2, WAIT_LO=3.
- IDLE:
  - send=1 captures word into the shift register, sets bit counter=WIDTH-1, busy=1, tx_bit=word[WIDTH-1], and moves to SETUP.
  - send is ignored whenever busy=1.
- SETUP:
  - tx_bit is held and the counter counts SETUP_CYCLES cycles.
  - At the end of the count, tx_ready<=1 and the state moves to WAIT_HI.
  - tx_ready therefore rises exactly SETUP_CYCLES+1 edges after send is sampled for the first bit.
- WAIT_HI:
  - ack_s=1 sets tx_ready<=0 and moves to WAIT_LO.
  - tx_bit is unchanged while tx_ready=1.
- WAIT_LO, when ack_s=0:
  - If bit counter=0: done=1 for one cycle, busy<=0, tx_bit<=0, state IDLE.
  - Otherwise: shift left, tx_bit<=next bit, decrement the counter, state SETUP.
- tx_bit changes only in cycles where tx_ready=0 and ack_s=0. This guarantees setup and hold for the MBED.
- Timeout:
  - The timer clears on entry to WAIT_HI and WAIT_LO.
  - If it reaches ACK_TIMEOUT before the exit condition: tx_ready<=0, tx_bit<=0, busy<=0, timeout_err=1 for one cycle, state IDLE.
  - The aborted word is discarded; no retry.
- After done or timeout_err, send is accepted in the very next cycle, since the block is already in IDLE.
- An ack_s that is already high when WAIT_HI is entered (a stuck ack) satisfies WAIT_HI immediately. The transfer then relies on the WAIT_LO timeout for protection.
- Widths:
  - The bit counter is ceil(log2(WIDTH)) bits.
  - The timer is sized for max(SETUP_CYCLES, ACK_TIMEOUT); the SETUP count reuses the same timer.
  - No wrap-around is reachable, because the timer clears at every state entry.

Test Plan (bench uses SETUP_CYCLES=4, ACK_TIMEOUT=64, WIDTH=10):
- Nominal transfer: send with word=10'b1011001110; a model MBED raises tx_ack 3 cycles after tx_ready rises and drops it 3 cycles after tx_ready falls. Required: 10 handshakes; captured bits are 1,0,1,1,0,0,1,1,1,0; done pulses once; busy falls with done; tx_bit is stable whenever tx_ready=1.
- Send while busy: second send with word=10'h3FF during bit 3 of a word=10'h155 transfer. Required: the second send is ignored; received word is 10'h155; exactly one done.
- Ack never rises: send, tx_ack held 0. Required: timeout_err exactly 64 cycles after WAIT_HI entry (state_dbg=2); tx_ready=0, busy=0, no done; the next send is accepted.
- Ack stuck high after bit 5. Required: WAIT_LO timeout after 64 cycles; timeout_err=1; tx_ready=0; state_dbg returns to 0.
- Reset mid-transfer: reset asserted while state_dbg=2 during bit 4. Required: next edge gives all outputs 0 and no done/timeout_err; a following send with word=10'h2AA completes normally.
- Back-to-back words: send is asserted in the cycle after done. Required: accepted immediately; two complete words (10'h001 then 10'h200) received in order.

Source files
------------

// File: rtl/serial_status_tx.sv
// Bit-serial status transmitter: shifts a WIDTH-bit word out MSB first over a
// ready/bit/ack handshake, aborting if the MBED stalls in either ack phase.
module serial_status_tx #(
   parameter int WIDTH        = 10,
   parameter int SETUP_CYCLES = 24,
   parameter int ACK_TIMEOUT  = 240000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             send,
   input  logic [WIDTH-1:0] word,
   input  logic             tx_ack,
   output logic             tx_ready,
   output logic             tx_bit,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [1:0]       state_dbg
);
   localparam int TMAX = (SETUP_CYCLES > ACK_TIMEOUT) ? SETUP_CYCLES : ACK_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int CW   = $clog2(WIDTH);

   localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES);
   localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_INIT   = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   state_t           state_q;
   logic             ack_m_q;
   logic             ack_s_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [CW-1:0]    cnt_q;
   logic [TW-1:0]    timer_q;
   logic [TW-1:0]    timer_d;
   logic             tx_ready_q;
   logic             tx_bit_q;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;

   assign shift_d = shift_q << 1;
   assign timer_d = timer_q + 1'b1;

   // The timer is shared: it counts the bit setup time in SETUP and the ack wait
   // in WAIT_HI/WAIT_LO, clearing on every state entry so it can never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ack_m_q    <= 1'b0;
         ack_s_q    <= 1'b0;
         shift_q    <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         tx_ready_q <= 1'b0;
         tx_bit_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         ack_m_q   <= tx_ack;
         ack_s_q   <= ack_m_q;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (send) begin
                  shift_q  <= word;
                  cnt_q    <= CNT_INIT;
                  tx_bit_q <= word[WIDTH-1];
                  busy_q   <= 1'b1;
                  timer_q  <= '0;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               if (timer_q == SETUP_LAST) begin
                  tx_ready_q <= 1'b1;
                  timer_q    <= '0;
                  state_q    <= WAIT_HI;
               end else begin
                  timer_q <= timer_d;
               end
            end
            WAIT_HI: begin
               if (ack_s_q) begin
                  tx_ready_q <= 1'b0;
                  timer_q    <= '0;
                  state_q    <= WAIT_LO;
               end else if (timer_q == ACK_LAST) begin
                  tx_ready_q <= 1'b0;
                  tx_bit_q   <= 1'b0;
                  busy_q     <= 1'b0;
                  timeout_q  <= 1'b1;
                  timer_q    <= '0;
                  state_q    <= IDLE;
               end else begin
                  timer_q <= timer_d;
               end
            end
            WAIT_LO: begin
               // tx_bit only moves here, with ready low and ack low, so the MBED
               // always sees a settled bit.
               if (!ack_s_q) begin
                  timer_q <= '0;
                  if (cnt_q == '0) begin
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     tx_bit_q <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     shift_q  <= shift_d;
                     tx_bit_q <= shift_q[WIDTH-2];
                     cnt_q    <= cnt_q - 1'b1;
                     state_q  <= SETUP;
                  end
               end else if (timer_q == ACK_LAST) begin
                  tx_ready_q <= 1'b0;
                  tx_bit_q   <= 1'b0;
                  busy_q     <= 1'b0;
                  timeout_q  <= 1'b1;
                  timer_q    <= '0;
                  state_q    <= IDLE;
               end else begin
                  timer_q <= timer_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_ready    = tx_ready_q;
   assign tx_bit      = tx_bit_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_serial_status_tx.sv
// Bench for serial_status_tx: timestamp-based reference model, MBED responder
// with word scoreboard, and directed plus randomized transfers.
module tb_serial_status_tx;
   localparam int W = 10;
   localparam int S = 4;
   localparam int T = 64;

   logic         clk    = 1'b0;
   logic         reset  = 1'b1;
   logic         send   = 1'b0;
   logic [W-1:0] word   = '0;
   logic         tx_ack = 1'b0;
   logic         tx_ready;
   logic         tx_bit;
   logic         busy;
   logic         done;
   logic         timeout_err;
   logic [1:0]   state_dbg;

   serial_status_tx #(.WIDTH(W), .SETUP_CYCLES(S), .ACK_TIMEOUT(T)) dut (
      .clk         (clk),
      .reset       (reset),
      .send        (send),
      .word        (word),
      .tx_ack      (tx_ack),
      .tx_ready    (tx_ready),
      .tx_bit      (tx_bit),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: phase 0 idle, 1 bit setup, 2 awaiting ack high, 3 awaiting ack low.
   bit           m_act = 0, m_rdy = 0, m_bit = 0, m_done = 0, m_to = 0;
   bit           m_h1 = 0, m_h2 = 0;
   int           m_phase = 0, m_idx = 0, m_t0 = 0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] done_q[$];

   // MBED responder and receive-side scoreboard.
   int           mb_mode = 0, mb_stick_n = 0, mb_dhi = 3, mb_dlo = 3, mb_cnt = 0;
   bit           mb_stuck = 0, mb_prev_rdy = 0, mb_rise_bit = 0;
   logic [W-1:0] rx_bits = '0;
   int           rx_n = 0;
   logic [W-1:0] rx_log[$];
   int           rises = 0, n_done = 0, n_to = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   function automatic logic [W-1:0] rx_back(input int k);
      if (rx_log.size() > k) return rx_log[rx_log.size() - 1 - k];
      return 'x;
   endfunction

   // Advances the model by the clock edge just taken; ack is seen two edges late.
   task automatic model_step();
      bit ack_s;
      ack_s  = m_h2;
      m_done = 0;
      m_to   = 0;
      if (reset) begin
         m_act = 0; m_rdy = 0; m_bit = 0; m_phase = 0; m_h1 = 0; m_h2 = 0;
      end else begin
         if (!m_act) begin
            if (send) begin
               m_act = 1; m_word = word; m_idx = W - 1; m_bit = word[W-1];
               m_t0 = cyc; m_phase = 1;
            end
         end else begin
            case (m_phase)
               1: if (cyc == m_t0 + S + 1) begin
                     m_rdy = 1; m_phase = 2; m_t0 = cyc;
                  end
               2: if (ack_s) begin
                     m_rdy = 0; m_phase = 3; m_t0 = cyc;
                  end else if (cyc == m_t0 + T) begin
                     m_act = 0; m_rdy = 0; m_bit = 0; m_to = 1; m_phase = 0;
                  end
               3: if (!ack_s) begin
                     if (m_idx == 0) begin
                        m_done = 1; m_act = 0; m_bit = 0; m_phase = 0;
                        done_q.push_back(m_word);
                     end else begin
                        m_idx--; m_bit = m_word[m_idx]; m_t0 = cyc; m_phase = 1;
                     end
                  end else if (cyc == m_t0 + T) begin
                     m_act = 0; m_rdy = 0; m_bit = 0; m_to = 1; m_phase = 0;
                  end
               default: m_phase = 0;
            endcase
         end
         m_h2 = m_h1;
         m_h1 = tx_ack;
      end
   endtask

   task automatic mbed_step();
      if (reset) begin
         rx_n = 0; rx_bits = '0;
      end else begin
         if (tx_ready && !mb_prev_rdy) begin
            rx_bits = {rx_bits[W-2:0], tx_bit};
            rx_n++; rises++;
            mb_rise_bit = tx_bit;
         end else if (tx_ready) begin
            check("bit_stable_while_ready", 32'(tx_bit), 32'(mb_rise_bit));
         end
         if (done) begin
            n_done++;
            check("busy_low_with_done", 32'(busy), 0);
            check("bits_per_word", rx_n, W);
            check("done_has_word", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) check("rx_word", 32'(rx_bits), 32'(done_q.pop_front()));
            rx_log.push_back(rx_bits);
            rx_n = 0;
         end
         if (timeout_err) begin
            n_to++; rx_n = 0;
         end
      end
      if (mb_mode == 1) begin
         tx_ack = 1'b0; mb_cnt = 0;
      end else if (mb_stuck) begin
         tx_ack = 1'b1;
      end else if (tx_ready != tx_ack) begin
         mb_cnt++;
         if (mb_cnt >= (tx_ready ? mb_dhi : mb_dlo)) begin
            tx_ack = tx_ready; mb_cnt = 0;
            if (tx_ack && mb_mode == 2 && rises >= mb_stick_n) mb_stuck = 1;
         end
      end else begin
         mb_cnt = 0;
      end
      mb_prev_rdy = tx_ready;
   endtask

   task automatic tick();
      logic [6:0] exp_v;
      @(negedge clk);
      cyc++;
      model_step();
      exp_v = {m_rdy, m_bit, m_act, m_done, m_to, 2'(m_phase)};
      check("cycle_model", 32'({tx_ready, tx_bit, busy, done, timeout_err, state_dbg}), 32'(exp_v));
      mbed_step();
   endtask

   task automatic do_send(input logic [W-1:0] w);
      int k = 0;
      while (busy && k < 4000) begin tick(); k++; end
      check("idle_before_send", 32'(busy), 0);
      send = 1'b1; word = w;
      tick();
      send = 1'b0;
   endtask

   task automatic wait_done(input int target, input string nm);
      int k = 0;
      while (n_done < target && k < 4000) begin tick(); k++; end
      check(nm, n_done, target);
   endtask

   initial begin
      logic [W-1:0] w;
      int base_d, base_t, e;

      repeat (3) tick();
      check("reset_outputs", 32'({tx_ready, tx_bit, busy, done, timeout_err, state_dbg}), 0);
      reset = 1'b0;
      tick();

      // Nominal transfer with 3-cycle MBED response.
      rises = 0; base_d = n_done;
      do_send(10'b1011001110);
      e = 0;
      while (!tx_ready && e < 50) begin tick(); e++; end
      check("setup_latency", e, 5);
      wait_done(base_d + 1, "nominal_done");
      check("nominal_word", 32'(rx_back(0)), 32'h2CE);
      check("nominal_handshakes", rises, 10);
      repeat (10) tick();
      check("nominal_single_done", n_done - base_d, 1);

      // Send while busy is ignored.
      rises = 0; base_d = n_done;
      do_send(10'h155);
      e = 0;
      while (rises < 3 && e < 500) begin tick(); e++; end
      check("reached_bit3", rises, 3);
      send = 1'b1; word = 10'h3FF;
      tick();
      send = 1'b0;
      check("busy_during_ignored_send", 32'(busy), 1);
      wait_done(base_d + 1, "busy_send_done");
      check("busy_send_word", 32'(rx_back(0)), 32'h155);
      repeat (40) tick();
      check("busy_send_single_done", n_done - base_d, 1);

      // Ack never rises: WAIT_HI timeout.
      mb_mode = 1; base_d = n_done; base_t = n_to;
      do_send(W'($urandom));
      e = 0;
      while (state_dbg != 2'd2 && e < 50) begin tick(); e++; end
      check("reach_wait_hi", 32'(state_dbg), 2);
      e = 0;
      while (!timeout_err && e < 200) begin tick(); e++; end
      check("wait_hi_timeout_cycles", e, 64);
      check("hi_to_ready_low", 32'(tx_ready), 0);
      check("hi_to_busy_low", 32'(busy), 0);
      check("hi_to_state_idle", 32'(state_dbg), 0);
      check("hi_to_count", n_to - base_t, 1);
      check("hi_to_no_done", n_done - base_d, 0);
      mb_mode = 0; w = W'($urandom);
      send = 1'b1; word = w;
      tick();
      send = 1'b0;
      check("accept_after_timeout", 32'(busy), 1);
      wait_done(base_d + 1, "post_timeout_done");
      check("post_timeout_word", 32'(rx_back(0)), 32'(w));

      // Ack stuck high from bit 5: WAIT_LO timeout.
      mb_mode = 2; mb_stick_n = 5; rises = 0; base_d = n_done; base_t = n_to;
      do_send(W'($urandom));
      e = 0;
      while (!mb_stuck && e < 1000) begin tick(); e++; end
      check("ack_stuck_at_bit5", rises, 5);
      e = 0;
      while (state_dbg != 2'd3 && e < 50) begin tick(); e++; end
      check("reach_wait_lo", 32'(state_dbg), 3);
      e = 0;
      while (!timeout_err && e < 200) begin tick(); e++; end
      check("wait_lo_timeout_cycles", e, 64);
      check("lo_to_ready_low", 32'(tx_ready), 0);
      check("lo_to_state_idle", 32'(state_dbg), 0);
      check("lo_to_busy_low", 32'(busy), 0);
      check("lo_to_count", n_to - base_t, 1);
      check("lo_to_no_done", n_done - base_d, 0);
      mb_mode = 0; mb_stuck = 0;
      repeat (10) tick();

      // Reset during WAIT_HI of bit 4.
      rises = 0; base_d = n_done; base_t = n_to;
      do_send(W'($urandom));
      e = 0;
      while (!(rises >= 4 && state_dbg == 2'd2) && e < 1000) begin tick(); e++; end
      check("reach_bit4_wait_hi", 32'(state_dbg), 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_mid_outputs", 32'({tx_ready, tx_bit, busy, done, timeout_err, state_dbg}), 0);
      repeat (10) tick();
      check("reset_no_done", n_done - base_d, 0);
      check("reset_no_timeout", n_to - base_t, 0);
      do_send(10'h2AA);
      wait_done(base_d + 1, "after_reset_done");
      check("after_reset_word", 32'(rx_back(0)), 32'h2AA);

      // Back-to-back words: send in the cycle right after done.
      base_d = n_done;
      do_send(10'h001);
      e = 0;
      while (n_done == base_d && e < 1000) begin tick(); e++; end
      send = 1'b1; word = 10'h200;
      tick();
      send = 1'b0;
      check("b2b_accepted", 32'(busy), 1);
      wait_done(base_d + 2, "b2b_done");
      check("b2b_first", 32'(rx_back(1)), 32'h001);
      check("b2b_second", 32'(rx_back(0)), 32'h200);

      // Randomized words, MBED delays and stray sends while busy.
      for (int i = 0; i < 30; i++) begin
         mb_dhi = $urandom_range(1, 6);
         mb_dlo = $urandom_range(1, 6);
         base_d = n_done;
         w = W'($urandom);
         do_send(w);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 60)) tick();
            if (busy) begin
               send = 1'b1; word = W'($urandom);
               tick();
               send = 1'b0;
            end
         end
         wait_done(base_d + 1, "rand_done");
         check("rand_word", 32'(rx_back(0)), 32'(w));
      end

      repeat (5) tick();
      check("no_leftover_words", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
